// File: rtl/ps2_wasd_if.sv
// PS/2 pin inputs and decoded WASD/arrow key levels shared by the decoder and its driver.
interface ps2_wasd_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       w;
  logic       a;
  logic       s;
  logic       d;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_error;

  modport master (
    output ps2_clk, ps2_data,
    input  w, a, s, d, scan_code, scan_valid, frame_error
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output w, a, s, d, scan_code, scan_valid, frame_error
  );
endinterface

// File: rtl/ps2_wasd_decoder.sv
// PS/2 set-2 receiver producing active-low held-key levels for WASD and the arrow keys.
// States: IDLE = wait for start bit | DATA = 8 bits LSB first | PARITY = odd parity bit | STOP = stop bit
module ps2_wasd_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic   clk,
  input  logic   reset,
  ps2_wasd_if.slave bus
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic [FW-1:0] filt_cnt;
  logic          filt_q, filt_d1;
  logic          fall;
  logic [TW-1:0] tmr_q;
  logic          frame_active, timeout;
  state_t        state_q, state_d;
  logic          accept, err;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic          par_q;
  logic          e0_q, f0_q;
  logic [3:0]    keys_q;   // {w, a, s, d}
  logic [7:0]    code_q;
  logic          valid_q, error_q;
  logic          hit;
  logic [1:0]    hit_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= bus.ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= bus.ps2_data;
      data_s2 <= data_s1;
    end
  end

  // Down-counter reloads whenever the sample agrees; a flip needs FILTER_LEN disagreeing samples in a row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_cnt <= FW'(FILTER_LEN - 1);
      filt_q   <= 1'b1;
      filt_d1  <= 1'b1;
    end else begin
      filt_d1 <= filt_q;
      if (clk_s2 == filt_q) begin
        filt_cnt <= FW'(FILTER_LEN - 1);
      end else if (filt_cnt == '0) begin
        filt_q   <= clk_s2;
        filt_cnt <= FW'(FILTER_LEN - 1);
      end else begin
        filt_cnt <= filt_cnt - 1'b1;
      end
    end
  end

  assign fall         = filt_d1 & ~filt_q;
  assign frame_active = (state_q != IDLE);
  assign timeout      = frame_active && !fall && (tmr_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr_q <= '0;
    end else if (fall) begin
      tmr_q <= TW'(TIMEOUT_CYCLES - 1);
    end else if (frame_active && tmr_q != '0) begin
      tmr_q <= tmr_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    err     = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall && !data_s2) state_d = DATA;
      end
      DATA: begin
        if (timeout) begin
          err     = 1'b1;
          state_d = IDLE;
        end else if (fall && bit_cnt == 3'd7) begin
          state_d = PARITY;
        end
      end
      PARITY: begin
        if (timeout) begin
          err     = 1'b1;
          state_d = IDLE;
        end else if (fall) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (timeout) begin
          err     = 1'b1;
          state_d = IDLE;
        end else if (fall) begin
          state_d = IDLE;
          if (data_s2 && (^{shift_q, par_q})) accept = 1'b1;
          else                                err    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hit     = 1'b0;
    hit_idx = 2'd0;
    if (e0_q) begin
      case (shift_q)
        8'h75: begin hit = 1'b1; hit_idx = 2'd3; end
        8'h6B: begin hit = 1'b1; hit_idx = 2'd2; end
        8'h72: begin hit = 1'b1; hit_idx = 2'd1; end
        8'h74: begin hit = 1'b1; hit_idx = 2'd0; end
        default: ;
      endcase
    end else begin
      case (shift_q)
        8'h1D: begin hit = 1'b1; hit_idx = 2'd3; end
        8'h1C: begin hit = 1'b1; hit_idx = 2'd2; end
        8'h1B: begin hit = 1'b1; hit_idx = 2'd1; end
        8'h23: begin hit = 1'b1; hit_idx = 2'd0; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      e0_q    <= 1'b0;
      f0_q    <= 1'b0;
      keys_q  <= 4'hF;
      code_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      valid_q <= accept;
      error_q <= err;
      if (fall) begin
        case (state_q)
          IDLE: bit_cnt <= '0;
          DATA: begin
            shift_q <= {data_s2, shift_q[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: par_q <= data_s2;
          default: ;
        endcase
      end
      if (err) begin
        e0_q <= 1'b0;
        f0_q <= 1'b0;
      end
      if (accept) begin
        code_q <= shift_q;
        if (shift_q == 8'hE0) begin
          e0_q <= 1'b1;
        end else if (shift_q == 8'hF0) begin
          f0_q <= 1'b1;
        end else begin
          if (hit) keys_q[hit_idx] <= f0_q;
          e0_q <= 1'b0;
          f0_q <= 1'b0;
        end
      end
    end
  end

  assign bus.w           = keys_q[3];
  assign bus.a           = keys_q[2];
  assign bus.s           = keys_q[1];
  assign bus.d           = keys_q[0];
  assign bus.scan_code   = code_q;
  assign bus.scan_valid  = valid_q;
  assign bus.frame_error = error_q;

endmodule

// File: tb/tb_ps2_wasd_decoder.sv
// Directed bench for ps2_wasd_decoder: frame table plus reset, glitch, timeout and mid-frame reset sequences.
module tb_ps2_wasd_decoder;
  localparam int FL = 8;
  localparam int TO = 5000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ps2_wasd_if bus();

  ps2_wasd_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] code;
    bit         bad_par;
    bit         bad_stop;
    logic [3:0] keys;
    logic [7:0] scode;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int fails  = 0;
  int v_cnt  = 0;
  int e_cnt  = 0;
  logic [5:0] pre_s, post_s;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] keys_now();
    return {bus.w, bus.a, bus.s, bus.d};
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.scan_valid) v_cnt++;
      if (bus.frame_error) e_cnt++;
      if (bus.scan_valid && bus.frame_error) begin
        checks++;
        fails++;
        $display("FAIL pulse_overlap: scan_valid and frame_error both 1 at %0t", $time);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One PS/2 bit: data set mid-high, clock low 20 cycles, high 20 cycles.
  task automatic ps2_bit(input logic b, input bit capture);
    bus.ps2_data = b;
    tick(10);
    bus.ps2_clk = 1'b0;
    if (capture) begin
      tick(10);
      pre_s = {keys_now(), bus.scan_valid, bus.frame_error};
      tick(1);
      post_s = {keys_now(), bus.scan_valid, bus.frame_error};
      tick(9);
    end else begin
      tick(20);
    end
    bus.ps2_clk = 1'b1;
    tick(20);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
    ps2_bit((~^b) ^ bad_par, 1'b0);
    ps2_bit(~bad_stop, 1'b1);
    bus.ps2_data = 1'b1;
    tick(30);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(b[i], 1'b0);
    bus.ps2_data = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] prev_keys;
    int v0, e0, n;
    bit good, ok;

    tbl.push_back('{8'h1D, 1'b0, 1'b0, 4'b0111, 8'h1D});
    tbl.push_back('{8'hF0, 1'b0, 1'b0, 4'b0111, 8'hF0});
    tbl.push_back('{8'h1D, 1'b0, 1'b0, 4'b1111, 8'h1D});
    tbl.push_back('{8'hE0, 1'b0, 1'b0, 4'b1111, 8'hE0});
    tbl.push_back('{8'h74, 1'b0, 1'b0, 4'b1110, 8'h74});
    tbl.push_back('{8'h1C, 1'b0, 1'b0, 4'b1010, 8'h1C});
    tbl.push_back('{8'hE0, 1'b0, 1'b0, 4'b1010, 8'hE0});
    tbl.push_back('{8'hF0, 1'b0, 1'b0, 4'b1010, 8'hF0});
    tbl.push_back('{8'h74, 1'b0, 1'b0, 4'b1011, 8'h74});
    tbl.push_back('{8'h1D, 1'b1, 1'b0, 4'b1011, 8'h74});
    tbl.push_back('{8'h1D, 1'b0, 1'b1, 4'b1011, 8'h74});
    tbl.push_back('{8'hF0, 1'b0, 1'b0, 4'b1011, 8'hF0});
    tbl.push_back('{8'h1D, 1'b1, 1'b0, 4'b1011, 8'hF0});
    tbl.push_back('{8'h1D, 1'b0, 1'b0, 4'b0011, 8'h1D});
    tbl.push_back('{8'hAA, 1'b0, 1'b0, 4'b0011, 8'hAA});
    tbl.push_back('{8'h1C, 1'b0, 1'b0, 4'b0011, 8'h1C});
    tbl.push_back('{8'h1C, 1'b0, 1'b0, 4'b0011, 8'h1C});
    tbl.push_back('{8'hE0, 1'b0, 1'b0, 4'b0011, 8'hE0});
    tbl.push_back('{8'h75, 1'b0, 1'b0, 4'b0011, 8'h75});
    tbl.push_back('{8'hE0, 1'b0, 1'b0, 4'b0011, 8'hE0});
    tbl.push_back('{8'hF0, 1'b0, 1'b0, 4'b0011, 8'hF0});
    tbl.push_back('{8'h6B, 1'b0, 1'b0, 4'b0111, 8'h6B});
    tbl.push_back('{8'hE1, 1'b0, 1'b0, 4'b0111, 8'hE1});
    tbl.push_back('{8'hF0, 1'b0, 1'b0, 4'b0111, 8'hF0});
    tbl.push_back('{8'h1D, 1'b0, 1'b0, 4'b1111, 8'h1D});

    // Reset with idle pins
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    reset = 1'b1;
    tick(3);
    check("reset_keys", int'(keys_now()), 4'hF);
    check("reset_scan_code", int'(bus.scan_code), 0);
    check("reset_valid", int'(bus.scan_valid), 0);
    check("reset_error", int'(bus.frame_error), 0);
    reset = 1'b0;
    tick(5);

    // Short clock glitch with data low must not look like a start bit
    bus.ps2_data = 1'b0;
    bus.ps2_clk  = 1'b0;
    tick(FL - 2);
    bus.ps2_clk  = 1'b1;
    tick(10);
    bus.ps2_data = 1'b1;
    tick(20);
    check("glitch_valid_pulses", v_cnt, 0);
    check("glitch_error_pulses", e_cnt, 0);
    check("glitch_keys", int'(keys_now()), 4'hF);

    prev_keys = 4'hF;
    foreach (tbl[i]) begin
      good = !(tbl[i].bad_par || tbl[i].bad_stop);
      v0 = v_cnt;
      e0 = e_cnt;
      send_frame(tbl[i].code, tbl[i].bad_par, tbl[i].bad_stop);
      check($sformatf("vec%0d_keys", i), int'(keys_now()), int'(tbl[i].keys));
      check($sformatf("vec%0d_scan_code", i), int'(bus.scan_code), int'(tbl[i].scode));
      check($sformatf("vec%0d_valid_count", i), v_cnt - v0, good ? 1 : 0);
      check($sformatf("vec%0d_error_count", i), e_cnt - e0, good ? 0 : 1);
      check($sformatf("vec%0d_pre_edge", i), int'(pre_s), int'({prev_keys, 2'b00}));
      check($sformatf("vec%0d_post_edge", i), int'(post_s),
            int'({tbl[i].keys, good ? 2'b10 : 2'b01}));
      prev_keys = tbl[i].keys;
    end

    // Partial frame then silence: timeout counted from the last internal falling edge
    v0 = v_cnt;
    e0 = e_cnt;
    send_partial(8'h0F, 4);
    n = 40;
    while (!bus.frame_error && n < 6000) begin
      tick(1);
      n++;
    end
    ok = (n >= TO) && (n <= TO + 20);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL timeout_latency: frame_error seen %0d cycles after last pin edge, expected %0d..%0d",
               n, TO, TO + 20);
    end
    tick(5);
    check("timeout_error_count", e_cnt - e0, 1);
    check("timeout_valid_count", v_cnt - v0, 0);
    send_frame(8'h1B, 1'b0, 1'b0);
    check("after_timeout_keys", int'(keys_now()), 4'b1101);
    check("after_timeout_scan_code", int'(bus.scan_code), 8'h1B);

    // Reset in the middle of a frame
    send_frame(8'h1C, 1'b0, 1'b0);
    check("pre_reset_keys", int'(keys_now()), 4'b1001);
    v0 = v_cnt;
    e0 = e_cnt;
    send_partial(8'h55, 3);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    check("midreset_keys", int'(keys_now()), 4'hF);
    tick(100);
    check("midreset_valid_count", v_cnt - v0, 0);
    check("midreset_error_count", e_cnt - e0, 0);
    send_frame(8'h1D, 1'b0, 1'b0);
    check("post_reset_keys", int'(keys_now()), 4'b0111);
    check("post_reset_scan_code", int'(bus.scan_code), 8'h1D);
    check("post_reset_valid_count", v_cnt - v0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/ps2_wasd_decoder.md
Name: ps2_wasd_decoder

Overview:
- Receives device-to-host frames from a PS/2 keyboard and turns them into the held-key level signals `w`, `a`, `s`, `d` that PlayerControl consumes.
- Outputs are active-low: 0 means held, 1 means released.
- Decodes scan-code set 2 make codes, break codes (F0 prefix) and extended codes (E0 prefix). WASD and the arrow keys both drive the same four outputs.
- Sits between the board PS/2 pins and the game logic, in the same clock domain as PlayerControl.

Parameters:
- FILTER_LEN, 8, consecutive identical samples required before the filtered ps2_clk level changes.
- TIMEOUT_CYCLES, 50000, clk cycles allowed between falling edges inside a frame before the frame is aborted.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- ps2_clk  input  1  raw PS/2 clock from the pin, asynchronous
- ps2_data  input  1  raw PS/2 data from the pin, asynchronous
- w  output  1  up held (0) or released (1); W (1D) or E0 75
- a  output  1  left held (0) or released (1); A (1C) or E0 6B
- s  output  1  down held (0) or released (1); S (1B) or E0 72
- d  output  1  right held (0) or released (1); D (23) or E0 74
- scan_code  output  8  last correctly received byte
- scan_valid  output  1  one-cycle pulse when scan_code updates
- frame_error  output  1  one-cycle pulse when a frame is aborted

Behaviour:
- Reset (asynchronous, active-high):
  - w, a, s, d = 1; scan_code = 0; scan_valid = 0; frame_error = 0.
  - FSM returns to IDLE; E0/F0 flags, bit counter, shift register and timeout counter are cleared; filtered clock = 1.
  - Reset asserted mid-frame discards the partial frame and produces no pulse.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchroniser.
  - The filtered clock changes level only after FILTER_LEN consecutive equal synchronised samples.
  - A falling edge means the filtered clock goes 1 to 0; ps2_data (synchronised) is sampled in that same cycle.
- Receive FSM, one transition per falling edge unless noted:
  - IDLE: if sampled data = 0 (start bit), go to DATA with bit count = 0. If data = 1, stay in IDLE with no error.
  - DATA: shift bits in LSB first. After the 8th bit, go to PARITY.
  - PARITY: store the bit. The frame is good if the XOR of the 8 data bits and the parity bit = 1 (odd parity). Go to STOP.
  - STOP: if data = 1 and parity is good, the byte is accepted. Otherwise frame_error pulses. Either way, return to IDLE.
  - Timeout: in DATA, PARITY or STOP, the counter is cleared on every falling edge. When it reaches TIMEOUT_CYCLES, frame_error pulses and the FSM returns to IDLE.
  - Any frame error also clears the E0 and F0 flags.
- Byte accept timing:
  - scan_code and scan_valid are registered in the cycle after the stop-bit edge.
  - w/a/s/d updates land in that same cycle.
  - Latency from the stop-bit falling edge to outputs is exactly 1 clk.
- Key decode, per accepted byte:
  - E0: set the E0 flag. No key change.
  - F0: set the F0 flag. No key change.
  - Any other byte: look it up in the table selected by the E0 flag (plain table or E0 table).
    - On a match, the mapped output becomes 0 if F0 = 0 (make) or 1 if F0 = 1 (break).
    - Both flags then clear, whether or not the byte matched.
  - Unmapped bytes (e.g. AA, FA, E1) change nothing except clearing the flags.
- Key independence and repeats:
  - Each key is tracked independently; several outputs may be 0 together. PlayerControl resolves priority.
  - Typematic repeat of a make code leaves a held key at 0.
  - A break code for a key that is not held is harmless.
  - A plain code and its arrow alias share one output bit, so the last event wins.
- scan_valid pulses for every accepted byte, including E0 and F0. scan_valid and frame_error are never asserted in the same cycle.

Test Plan:
- Reset:
  - Stimulus: assert reset for 3 clk while ps2_clk = ps2_data = 1.
  - Required: w = a = s = d = 1, scan_valid = 0, frame_error = 0.
  - Stimulus: then glitch ps2_clk low for FILTER_LEN−2 cycles.
  - Required: no FSM movement, no pulses.
- Make then break:
  - Stimulus: send byte 1D with good parity.
  - Required: scan_code = 1D, one scan_valid pulse, w = 0 exactly one clk after the stop-bit edge.
  - Stimulus: send F0 then 1D.
  - Required: two scan_valid pulses; w = 1 after the second byte.
- Extended arrow plus concurrent key:
  - Stimulus: send E0 74 (right make).
  - Required: d = 0.
  - Stimulus: send 1C (A make).
  - Required: a = 0 and d = 0 together.
  - Stimulus: send E0 F0 74.
  - Required: d = 1, a still 0.
- Bad frames:
  - Stimulus: send 1D with parity bit inverted.
  - Required: frame_error pulse, no scan_valid, w stays 1.
  - Stimulus: send 1D with stop bit = 0.
  - Required: frame_error pulse.
  - Stimulus: send F0, then a corrupted frame, then 1D.
  - Required: w = 0, because the error cleared the F0 flag.
- Timeout:
  - Setup: TIMEOUT_CYCLES = 5000.
  - Stimulus: send a start bit plus 4 data bits, then hold ps2_clk high.
  - Required: frame_error pulse at 5000 cycles after the last edge; FSM back in IDLE.
  - Stimulus: then send a full 1B frame.
  - Required: s = 0.
- Unmapped byte, repeat and reset mid-frame:
  - Stimulus: send AA.
  - Required: scan_valid with scan_code = AA; keys unchanged.
  - Stimulus: send 1C twice.
  - Required: a stays 0.
  - Stimulus: assert reset mid-frame.
  - Required: all keys return to 1; the next complete frame decodes normally.
